// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the bus masters and the round-robin arbiter.
// The arbiter connects through the slave modport and the requesters through master.
interface bus_arbiter_rr_if #(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned MAX_HOLD    = 16
);
   localparam int unsigned OW = $clog2(NUM_MASTERS);
   localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] grnt;
   logic [OW-1:0]          owner;
   logic                   grnt_valid;
   logic [HW-1:0]          hold_cnt;

   modport master (output req, input grnt, owner, grnt_valid, hold_cnt);
   modport slave  (input req, output grnt, owner, grnt_valid, hold_cnt);
endinterface

// File: rtl/bus_arbiter_rr.sv
// Parametrised round-robin bus arbiter with a burst-length limit and a
// selectable park/no-park idle policy. All outputs come straight from flops.
module bus_arbiter_rr #(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned MAX_HOLD    = 16,
   parameter bit          PARK        = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   bus_arbiter_rr_if.slave  bus
);
   localparam int unsigned OW   = $clog2(NUM_MASTERS);
   localparam int unsigned HW   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam int unsigned HSAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;

   typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;
   localparam state_t RST_STATE = PARK ? GRANTED : IDLE;

   state_t                 state_q, state_d;
   logic [OW-1:0]          owner_q, owner_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic [NUM_MASTERS-1:0] grnt_q, grnt_d;
   logic                   valid_q, valid_d;

   logic [NUM_MASTERS-1:0] own_mask, hi_mask, req_hi;
   logic [OW-1:0]          win;
   logic                   req_own, req_others, req_any, limit_hit;

   function automatic logic [OW-1:0] lowest_set(input logic [NUM_MASTERS-1:0] v);
      logic [OW-1:0] r;
      r = '0;
      for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
         if (v[i]) r = OW'(i);
      end
      return r;
   endfunction

   // Masks relative to the current owner; winner is the first requester above
   // the owner, otherwise the lowest requester overall (owner itself comes last).
   always_comb begin
      own_mask = '0;
      hi_mask  = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         own_mask[i] = (i == 32'(owner_q));
         hi_mask[i]  = (i >  32'(owner_q));
      end
      req_hi     = bus.req & hi_mask;
      win        = (|req_hi) ? lowest_set(req_hi) : lowest_set(bus.req);
      req_own    = |(bus.req & own_mask);
      req_others = |(bus.req & ~own_mask);
      req_any    = |bus.req;
      limit_hit  = (MAX_HOLD != 0) && (32'(hold_q) >= MAX_HOLD) && req_others;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RST_STATE;
         owner_q <= '0;
         hold_q  <= '0;
         grnt_q  <= PARK ? NUM_MASTERS'(1) : '0;
         valid_q <= PARK;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
         grnt_q  <= grnt_d;
         valid_q <= valid_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      hold_d  = hold_q;
      if (32'(owner_q) >= NUM_MASTERS) begin
         // Out-of-range owner can only come from corruption; recover as if reset.
         state_d = RST_STATE;
         owner_d = '0;
         hold_d  = '0;
      end else begin
         case (state_q)
            GRANTED: begin
               if (req_own && !limit_hit) begin
                  if (32'(hold_q) < HSAT) hold_d = hold_q + HW'(1);
               end else if (req_others) begin
                  owner_d = win;
                  hold_d  = HW'(1);
               end else begin
                  hold_d = '0;
                  if (!PARK) state_d = IDLE;
               end
            end
            default: begin
               if (req_any) begin
                  state_d = GRANTED;
                  owner_d = win;
                  hold_d  = HW'(1);
               end
            end
         endcase
      end
   end

   // Output decode from the next state, registered alongside it
   always_comb begin
      grnt_d  = '0;
      valid_d = 1'b0;
      if (state_d == GRANTED) begin
         grnt_d  = NUM_MASTERS'(1) << owner_d;
         valid_d = 1'b1;
      end
   end

   assign bus.grnt       = grnt_q;
   assign bus.owner      = owner_q;
   assign bus.grnt_valid = valid_q;
   assign bus.hold_cnt   = hold_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: three configurations driven side by side,
// expected outputs come from a rule-level reference model.
module tb_bus_arbiter_rr;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bus_arbiter_rr_if #(.NUM_MASTERS(4), .MAX_HOLD(4)) ia ();
   bus_arbiter_rr_if #(.NUM_MASTERS(5), .MAX_HOLD(3)) ib ();
   bus_arbiter_rr_if #(.NUM_MASTERS(4), .MAX_HOLD(0)) ic ();

   bus_arbiter_rr #(.NUM_MASTERS(4), .MAX_HOLD(4), .PARK(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   bus_arbiter_rr #(.NUM_MASTERS(5), .MAX_HOLD(3), .PARK(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
   bus_arbiter_rr #(.NUM_MASTERS(4), .MAX_HOLD(0), .PARK(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

   typedef struct {
      logic [2:0][31:0] grnt;
      logic [2:0][31:0] owner;
      logic [2:0][31:0] valid;
      logic [2:0][31:0] hold;
   } exp_t;

   exp_t sbq[$];
   int total = 0;
   int bad   = 0;

   int    cfg_n   [3] = '{4, 5, 4};
   int    cfg_mh  [3] = '{4, 3, 0};
   int    cfg_park[3] = '{1, 0, 1};
   string cfg_name[3] = '{"a", "b", "c"};

   // Reference model state: who owns the bus, whether a grant is out, burst length
   int  m_own [3];
   bit  m_gnt [3];
   int  m_hold[3];

   function automatic bit has(input int rq, input int idx);
      return ((rq >> idx) & 1) != 0;
   endfunction

   function void model_step(input int i, input bit r, input int rq);
      int n, winner, sat;
      bit others;
      n      = cfg_n[i];
      sat    = (cfg_mh[i] == 0) ? 1 : cfg_mh[i];
      winner = -1;
      for (int k = 1; k <= n; k++) begin
         int idx;
         idx = (m_own[i] + k) % n;
         if (winner < 0 && has(rq, idx)) winner = idx;
      end
      others = (rq & ~(1 << m_own[i])) != 0;
      if (r) begin
         m_own[i] = 0; m_hold[i] = 0; m_gnt[i] = (cfg_park[i] != 0);
      end else if (!m_gnt[i]) begin
         if (winner >= 0) begin
            m_own[i] = winner; m_hold[i] = 1; m_gnt[i] = 1'b1;
         end
      end else if (has(rq, m_own[i])) begin
         if (cfg_mh[i] == 0 || m_hold[i] < cfg_mh[i] || !others) begin
            if (m_hold[i] < sat) m_hold[i]++;
         end else begin
            m_own[i] = winner; m_hold[i] = 1;
         end
      end else if (others) begin
         m_own[i] = winner; m_hold[i] = 1;
      end else begin
         m_hold[i] = 0;
         m_gnt[i]  = (cfg_park[i] != 0);
      end
   endfunction

   task automatic cycle(input bit r, input int ra, input int rb, input int rc);
      exp_t e;
      int rq[3];
      @(negedge clk);
      rq[0] = ra & 15; rq[1] = rb & 31; rq[2] = rc & 15;
      rst = r;
      ia.req = 4'(rq[0]);
      ib.req = 5'(rq[1]);
      ic.req = 4'(rq[2]);
      for (int i = 0; i < 3; i++) begin
         model_step(i, r, rq[i]);
         e.grnt[i]  = m_gnt[i] ? (32'd1 << m_own[i]) : 32'd0;
         e.owner[i] = 32'(m_own[i]);
         e.valid[i] = 32'(m_gnt[i]);
         e.hold[i]  = 32'(m_hold[i]);
      end
      sbq.push_back(e);
   endtask

   function automatic int flips(input int n);
      int m;
      m = 0;
      for (int b = 0; b < n; b++) begin
         if ($urandom_range(0, 4) == 0) m |= (1 << b);
      end
      return m;
   endfunction

   task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s at %0t: got %0h expected %0h", cfg_name[i], name, $time, act, exp);
      end
   endtask

   // Monitor: every cycle the DUTs present fresh registered outputs
   initial begin
      exp_t e;
      logic [2:0][31:0] g, o, v, h;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            g[0] = 32'(ia.grnt); o[0] = 32'(ia.owner); v[0] = 32'(ia.grnt_valid); h[0] = 32'(ia.hold_cnt);
            g[1] = 32'(ib.grnt); o[1] = 32'(ib.owner); v[1] = 32'(ib.grnt_valid); h[1] = 32'(ib.hold_cnt);
            g[2] = 32'(ic.grnt); o[2] = 32'(ic.owner); v[2] = 32'(ic.grnt_valid); h[2] = 32'(ic.hold_cnt);
            for (int i = 0; i < 3; i++) begin
               check("grnt",       i, g[i], e.grnt[i]);
               check("owner",      i, o[i], e.owner[i]);
               check("grnt_valid", i, v[i], e.valid[i]);
               check("hold_cnt",   i, h[i], e.hold[i]);
            end
         end
      end
   end

   // Stimulus
   initial begin
      int ra, rb, rc, budget;
      ia.req = '0; ib.req = '0; ic.req = '0;
      for (int i = 0; i < 3; i++) begin
         m_own[i] = 0; m_hold[i] = 0; m_gnt[i] = 1'b0;
      end

      cycle(1'b1, 0, 0, 0);
      cycle(1'b1, 0, 0, 0);

      // a: burst limit on 0011; b: wrap from owner 4 through idle; c: rotation
      cycle(1'b0, 4'b0010, 5'b10000, 15 & ~(1 << m_own[2]));
      cycle(1'b0, 4'b0011, 5'b00000, 15 & ~(1 << m_own[2]));
      cycle(1'b0, 4'b0011, 5'b00000, 15 & ~(1 << m_own[2]));
      for (int c = 0; c < 12; c++) cycle(1'b0, 4'b0011, 5'b00011, 15 & ~(1 << m_own[2]));
      // uncontested hold saturates
      for (int c = 0; c < 10; c++) cycle(1'b0, 4'b0100, 5'b00100, 4'b0100);
      // reset mid-burst
      cycle(1'b1, 4'b0100, 5'b00100, 4'b0100);
      cycle(1'b0, 4'b0100, 5'b00100, 4'b0100);

      ra = 0; rb = 0; rc = 0;
      for (int c = 0; c < 3000; c++) begin
         ra ^= flips(4); rb ^= flips(5); rc ^= flips(4);
         if ($urandom_range(0, 31) == 0) ra = 0;
         if ($urandom_range(0, 31) == 0) rb = 0;
         if ($urandom_range(0, 31) == 0) rc = 0;
         cycle($urandom_range(0, 63) == 0, ra, rb, rc);
      end

      budget = 10;
      while (sbq.size() > 0 && budget > 0) begin
         @(posedge clk);
         #2;
         budget--;
      end
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised round-robin bus arbiter that grants one of `NUM_MASTERS` bus masters at a time. It is the generalised successor of the fixed four-master arbiter. It adds a configurable master count, a burst-length limit that preempts a hogging owner, and a selectable park/no-park idle policy. It sits between the master request lines and the bus address/data multiplexers, whose select inputs are driven by `owner` and `grnt`.

## Interface
- `NUM_MASTERS`, default 4: number of masters, 2..16.
- `MAX_HOLD`, default 16: maximum consecutive grant cycles for an owner while others request. 0 means unlimited, i.e. hold while requesting.
- `PARK`, default 1: 1 keeps the grant on the last owner when nobody requests; 0 drops all grants when idle.
- `OW`, derived as `$clog2(NUM_MASTERS)`: owner index width.
- `clk`, input, 1: clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, `NUM_MASTERS`: per-master bus request; bit i belongs to master i.
- `grnt`, output, `NUM_MASTERS`: registered grant, one-hot or all-zero.
- `owner`, output, `OW`: index of the current or last owner.
- `grnt_valid`, output, 1: high when any `grnt` bit is set.
- `hold_cnt`, output, `$clog2(MAX_HOLD+1)` (minimum 1): number of cycles the current owner has held the grant, saturating.

## Operation
- Reset values:
  - `owner` = 0.
  - `hold_cnt` = 0.
  - PARK=1: `grnt` = 1 (master 0), `grnt_valid` = 1.
  - PARK=0: `grnt` = 0, `grnt_valid` = 0.
- States:
  - GRANTED: exactly one `grnt` bit is set.
  - IDLE: no grant. Only reachable when PARK=0.
- Search order: `owner+1`, `owner+2`, … modulo `NUM_MASTERS`, ending with `owner` itself. The first requester found is the winner. The priority rotation is 0,1,…,N-1,0.
- GRANTED, `req[owner]`=1:
  - Stay when MAX_HOLD=0, or `hold_cnt` < MAX_HOLD, or no other `req` bit is set. `hold_cnt` increments and saturates at MAX_HOLD.
  - Otherwise (limit reached and another master requests) hand over to the winner and set `hold_cnt` to 1.
- GRANTED, `req[owner]`=0:
  - If any other request is present, hand over to the winner and set `hold_cnt` to 1.
  - If none, PARK=1 keeps `grnt` and `owner` with `hold_cnt` at 0; PARK=0 moves to IDLE with `grnt` at 0, `owner` retained, `hold_cnt` at 0.
- IDLE: if any request is present, grant the winner searched from `owner+1` and set `hold_cnt` to 1. Otherwise stay in IDLE.
- Parked owner re-requesting: `hold_cnt` restarts at 1 and no handover occurs unless the limit rule fires.
- Non-power-of-two `NUM_MASTERS`: the search wraps at N-1 to 0. Owner values ≥ N are unreachable; if reached, they are treated as reset (owner 0).
- `req` bits of non-owners never affect `grnt` except through the handover rules above.

## Timing
- `req` is sampled on the rising edge. The new `grnt`/`owner` is visible in the cycle after the edge, giving 1-cycle arbitration latency.
- Handover has no dead cycle: the old grant falls and the new grant rises on the same edge. `grnt` is never multi-hot.
- A master that drops `req` in cycle t loses the grant from cycle t+1. Its request must be held until the grant is seen.
- Limit preemption: the owner keeps the grant for exactly MAX_HOLD cycles when contested, then switches on the next edge.
- `rst` high at any edge forces reset values on the following cycle, overriding every other event. Reset mid-burst drops the grant immediately; with PARK=1 it moves to master 0.
- All outputs are registered and there are no combinational paths from `req` to outputs.

## Test plan
- Reset, PARK=1, N=4: `rst`=1 for 2 cycles with `req`=0 -> `grnt`=0001, `owner`=0, `grnt_valid`=1, `hold_cnt`=0. With PARK=0 -> `grnt`=0000, `grnt_valid`=0.
- Rotation with MAX_HOLD=0: `req`=1111 held, each owner drops its req for one cycle in turn -> grant sequence 0001→0010→0100→1000→0001, one cycle per switch.
- Burst limit with MAX_HOLD=4: master 1 granted, `req`=0011 constant -> `grnt`=0010 for 4 cycles (`hold_cnt` 1..4), then 0001 for 4 cycles, then back to 0010.
- Uncontested hold: MAX_HOLD=4, `req`=0100 for 10 cycles -> `grnt` stays 0100 and `hold_cnt` saturates at 4.
- Idle/park with N=5, PARK=0: owner 4 releases with `req`=00000 -> IDLE; then `req`=00011 -> `grnt`=00001 (wrap from 4 to 0).
- Reset mid-burst: owner 2 with `hold_cnt`=3, `rst` pulsed for 1 cycle -> next cycle `owner`=0, `hold_cnt`=0. `grnt` is 0001 (PARK=1) or 0000 (PARK=0).
